// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared encodings for the byte-lane data memory and its load aligner.
// Revision 1.0
`default_nettype none

package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/data_memory_bytelane_load_align.sv
// load_align: picks the addressed byte/half lane of a word and sign- or zero-extends it.
// Revision 1.0
`default_nettype none

module load_align
   import data_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted_w;

   always_comb begin
      shifted_w = word_i >> {lane_i, 3'b000};
      data_o    = '0;
      case (size_i)
         SZ_BYTE: data_o = {{24{~unsigned_i & shifted_w[7]}}, shifted_w[7:0]};
         SZ_HALF: data_o = {{16{~unsigned_i & shifted_w[15]}}, shifted_w[15:0]};
         SZ_WORD: data_o = shifted_w;
         default: data_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: byte-lane data memory with combinational loads and a streaming dump engine.
// Revision 1.0
`default_nettype none

module data_memory_bytelane
   import data_mem_pkg::*;
#(
   parameter int DEPTH  = 8192,
   parameter int ADDR_W = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_write,
   input  logic              mem_read,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              misaligned,
   output logic              busy,
   input  logic              dump_start,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [31:0]       dump_data,
   output logic              dump_done
);

   localparam int IDX_W = ADDR_W - 2;

   logic [31:0]      mem_q [DEPTH];
   logic [DEPTH-1:0] written_q;

   dump_state_t      state_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q;
   logic             dump_valid_q;
   logic             dump_done_q;
   logic [31:0]      dump_data_q;

   logic [IDX_W-1:0] word_idx_w;
   logic             store_en_w;
   logic [3:0]       lane_mask_w;
   logic [31:0]      store_data_w;
   logic [31:0]      aligned_w;

   assign word_idx_w = address[ADDR_W-1:2];

   always_comb begin
      misaligned = 1'b0;
      if (mem_read | mem_write) begin
         misaligned = (size == SZ_ILL)
                    | ((size == SZ_HALF) & address[0])
                    | ((size == SZ_WORD) & (address[1:0] != 2'b00));
      end
   end

   assign store_en_w = mem_write & ~misaligned & ~busy_q;

   // Narrow stores replicate their data across the word so each lane sees the right byte.
   always_comb begin
      lane_mask_w  = 4'b0000;
      store_data_w = write_data;
      case (size)
         SZ_BYTE: begin
            lane_mask_w  = 4'b0001 << address[1:0];
            store_data_w = {4{write_data[7:0]}};
         end
         SZ_HALF: begin
            lane_mask_w  = address[1] ? 4'b1100 : 4'b0011;
            store_data_w = {2{write_data[15:0]}};
         end
         SZ_WORD: lane_mask_w = 4'b1111;
         default: lane_mask_w = 4'b0000;
      endcase
   end

   always_ff @(posedge clock) begin
      if (store_en_w) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_mask_w[b]) begin
               mem_q[word_idx_w][8*b +: 8] <= store_data_w[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         written_q <= '0;
      end else if (store_en_w) begin
         written_q[word_idx_w] <= 1'b1;
      end
   end

   load_align u_load_align (
      .word_i     (mem_q[word_idx_w]),
      .size_i     (size),
      .lane_i     (address[1:0]),
      .unsigned_i (unsigned_ld),
      .data_o     (aligned_w)
   );

   assign read_data = (mem_read & ~misaligned) ? aligned_w : 32'h0;

   // Done is registered while leaving DONE, so an empty dump spans DEPTH+1 edges.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         dump_valid_q <= 1'b0;
         dump_done_q  <= 1'b0;
         dump_data_q  <= '0;
      end else begin
         dump_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dump_start) begin
                  state_q <= SCAN;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SCAN: begin
               if (written_q[idx_q]) begin
                  state_q      <= EMIT;
                  dump_valid_q <= 1'b1;
                  dump_data_q  <= mem_q[idx_q];
               end else if (idx_q == IDX_W'(DEPTH - 1)) begin
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            EMIT: begin
               if (dump_ready) begin
                  dump_valid_q <= 1'b0;
                  if (idx_q == IDX_W'(DEPTH - 1)) begin
                     state_q <= DONE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= SCAN;
                  end
               end
            end
            DONE: begin
               dump_done_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign dump_valid = dump_valid_q;
   assign dump_done  = dump_done_q;
   assign dump_data  = dump_data_q;
   assign dump_addr  = {idx_q, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_data_memory_bytelane.sv
// tb_data_memory_bytelane: directed and randomized checks against a byte-array reference model.
// Revision 1.0
`default_nettype none

module tb_data_memory_bytelane;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 6;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [5:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        misaligned;
   logic        busy;
   logic        dump_start;
   logic        dump_valid;
   logic        dump_ready;
   logic [5:0]  dump_addr;
   logic [31:0] dump_data;
   logic        dump_done;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem_m [64];
   bit          written_m [DEPTH];
   int          exp_idx [$];
   logic [31:0] exp_dat [$];

   data_memory_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .misaligned  (misaligned),
      .busy        (busy),
      .dump_start  (dump_start),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_addr   (dump_addr),
      .dump_data   (dump_data),
      .dump_done   (dump_done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit model_mis(bit we, bit re, logic [1:0] sz, logic [5:0] a);
      if (!(we || re)) return 1'b0;
      if (sz == 2'b11) return 1'b1;
      if (sz == 2'b01) return (a % 2) != 0;
      if (sz == 2'b10) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_word(int i);
      return {mem_m[4*i+3], mem_m[4*i+2], mem_m[4*i+1], mem_m[4*i]};
   endfunction

   function automatic logic [31:0] model_load(logic [5:0] a, logic [1:0] sz, bit uns);
      int b = int'(a);
      logic [15:0] h;
      case (sz)
         2'b00: return uns ? {24'h0, mem_m[b]} : {{24{mem_m[b][7]}}, mem_m[b]};
         2'b01: begin
            h = {mem_m[b+1], mem_m[b]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
         end
         2'b10: return model_word(b / 4);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_store(logic [5:0] a, logic [1:0] sz, logic [31:0] wd);
      int b = int'(a);
      int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++) mem_m[b+k] = wd[8*k +: 8];
      written_m[b/4] = 1'b1;
   endtask

   task automatic op(input bit we, input bit re, input logic [1:0] sz, input bit uns,
                     input logic [5:0] a, input logic [31:0] wd, output logic [31:0] rd);
      bit mis;
      @(negedge clock);
      mem_write = we; mem_read = re; size = sz; unsigned_ld = uns;
      address = a; write_data = wd;
      #1;
      mis = model_mis(we, re, sz, a);
      rd  = read_data;
      chk($sformatf("misaligned@%02h", a), 32'(misaligned), 32'(mis));
      chk($sformatf("read_data@%02h", a), read_data,
          (re && !mis) ? model_load(a, sz, uns) : 32'h0);
      @(posedge clock);
      if (we && !mis) model_store(a, sz, wd);
      #1;
      mem_write = 1'b0;
      mem_read  = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) written_m[i] = 1'b0;
   endtask

   task automatic run_dump(input int stall, input bit busy_store, output int done_cycle);
      int cyc;
      int stall_cnt;
      int dones;
      exp_idx.delete();
      exp_dat.delete();
      for (int i = 0; i < DEPTH; i++) begin
         if (written_m[i]) begin
            exp_idx.push_back(i);
            exp_dat.push_back(model_word(i));
         end
      end
      @(negedge clock);
      dump_start = 1'b1;
      @(posedge clock);
      #1 dump_start = 1'b0;
      cyc = 0; stall_cnt = 0; dones = 0; done_cycle = -1;
      while (cyc < 300 && dones == 0) begin
         @(negedge clock);
         mem_write = 1'b0;
         if (busy_store && cyc == 2) begin
            mem_write = 1'b1; size = 2'b10; address = 6'h20; write_data = 32'hDEADBEEF;
         end
         if (cyc == 1) chk("busy_during_dump", 32'(busy), 32'd1);
         if (dump_done === 1'b1) begin
            dones++;
            done_cycle = cyc;
         end
         dump_ready = 1'b0;
         if (dump_valid === 1'b1) begin
            if (exp_idx.size() == 0) begin
               chk("dump_extra_beat", 32'(dump_valid), 32'd0);
            end else begin
               chk("dump_addr", 32'(dump_addr), 32'(exp_idx[0] * 4));
               chk("dump_data", dump_data, exp_dat[0]);
               if (stall_cnt < stall) stall_cnt++;
               else dump_ready = 1'b1;
            end
         end
         @(posedge clock);
         cyc++;
         if (dump_ready) begin
            void'(exp_idx.pop_front());
            void'(exp_dat.pop_front());
            stall_cnt = 0;
         end
      end
      mem_write = 1'b0;
      dump_ready = 1'b0;
      chk("dump_done_seen", 32'(dones), 32'd1);
      chk("dump_beats_missing", 32'(exp_idx.size()), 32'd0);
      @(negedge clock);
      chk("dump_done_width", 32'(dump_done), 32'd0);
      chk("busy_after_dump", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          dc;
      int          seen;
      reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
      address = '0; write_data = '0; dump_start = 1'b0; dump_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Give every word a defined value, then clear the written flags only.
      for (int i = 0; i < DEPTH; i++) op(1, 0, 2'b10, 0, 6'(i * 4), $urandom, rd);
      pulse_reset();
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_dump_valid", 32'(dump_valid), 32'd0);
      chk("reset_dump_done", 32'(dump_done), 32'd0);
      chk("idle_read_data", read_data, 32'd0);
      op(0, 1, 2'b10, 0, 6'h14, 0, rd);

      // Empty dump
      run_dump(0, 0, dc);
      chk("empty_dump_latency", 32'(dc), 32'd17);

      // Loads with extension
      op(1, 0, 2'b10, 0, 6'h04, 32'h8899AABC, rd);
      op(0, 1, 2'b00, 0, 6'h04, 0, rd); chk("t1_lb", rd, 32'hFFFFFFBC);
      op(0, 1, 2'b00, 1, 6'h07, 0, rd); chk("t1_lbu", rd, 32'h00000088);
      op(0, 1, 2'b01, 0, 6'h06, 0, rd); chk("t1_lh", rd, 32'hFFFF8899);
      op(0, 1, 2'b01, 1, 6'h04, 0, rd); chk("t1_lhu", rd, 32'h0000AABC);

      // Byte-lane merging
      op(1, 0, 2'b10, 0, 6'h08, 32'h0, rd);
      op(1, 0, 2'b00, 0, 6'h0A, 32'h1234567F, rd);
      op(1, 0, 2'b01, 0, 6'h08, 32'hCAFEBEEF, rd);
      op(0, 1, 2'b10, 0, 6'h08, 0, rd); chk("t2_lw", rd, 32'h007FBEEF);

      // Faulting accesses
      op(0, 1, 2'b10, 0, 6'h05, 0, rd);
      op(1, 0, 2'b01, 0, 6'h03, 32'h5555AAAA, rd);
      op(1, 1, 2'b11, 0, 6'h04, 32'h11111111, rd);
      op(0, 1, 2'b10, 0, 6'h04, 0, rd); chk("t3_word_kept", rd, 32'h8899AABC);

      // Two-word dump with a stalled consumer and a store while busy
      pulse_reset();
      op(1, 0, 2'b10, 0, 6'h00, 32'hA5A5_0001, rd);
      op(1, 0, 2'b10, 0, 6'h3C, 32'h5A5A_000F, rd);
      run_dump(3, 1, dc);
      op(0, 1, 2'b10, 0, 6'h20, 0, rd);

      // Reset while a beat is presented
      pulse_reset();
      op(1, 0, 2'b10, 0, 6'h30, 32'h0BAD_F00D, rd);
      @(negedge clock);
      dump_start = 1'b1;
      @(negedge clock);
      dump_start = 1'b0;
      for (int i = 0; i < 40 && dump_valid !== 1'b1; i++) @(negedge clock);
      chk("t6_valid_reached", 32'(dump_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6_valid_async_drop", 32'(dump_valid), 32'd0);
      chk("t6_busy_async_drop", 32'(busy), 32'd0);
      seen = 0;
      repeat (2) begin
         @(negedge clock);
         if (dump_done === 1'b1) seen++;
      end
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) written_m[i] = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (dump_done === 1'b1) seen++;
      end
      chk("t6_no_done", 32'(seen), 32'd0);
      run_dump(0, 0, dc);
      chk("t6_redump_latency", 32'(dc), 32'd17);

      // Randomized traffic followed by a full dump
      for (int n = 0; n < 80; n++) begin
         op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            6'($urandom), $urandom, rd);
      end
      run_dump(int'($urandom_range(0, 2)), 0, dc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
